// File: rtl/square15_compressor.sv
// square15_compressor: registered bit-heap reducer for a 15x15 bit matrix.
// Column i holds 15 bits of weight 2^i; the 19-bit sum of all 225 bits is
// registered and presented one bit per output port, one cycle after capture.
module square15_compressor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] src0,
  input  logic [14:0] src1,
  input  logic [14:0] src2,
  input  logic [14:0] src3,
  input  logic [14:0] src4,
  input  logic [14:0] src5,
  input  logic [14:0] src6,
  input  logic [14:0] src7,
  input  logic [14:0] src8,
  input  logic [14:0] src9,
  input  logic [14:0] src10,
  input  logic [14:0] src11,
  input  logic [14:0] src12,
  input  logic [14:0] src13,
  input  logic [14:0] src14,
  output logic        dst0,
  output logic        dst1,
  output logic        dst2,
  output logic        dst3,
  output logic        dst4,
  output logic        dst5,
  output logic        dst6,
  output logic        dst7,
  output logic        dst8,
  output logic        dst9,
  output logic        dst10,
  output logic        dst11,
  output logic        dst12,
  output logic        dst13,
  output logic        dst14,
  output logic        dst15,
  output logic        dst16,
  output logic        dst17,
  output logic        dst18
);

  logic [14:0][14:0] cols;     // cols[i] = column i bit vector
  logic [14:0][3:0]  pc;       // per-column popcount, 0..15
  logic [18:0]       sum_d;
  logic [18:0]       sum_q;

  assign cols = {src14, src13, src12, src11, src10, src9, src8, src7,
                 src6,  src5,  src4,  src3,  src2,  src1, src0};

  // Per-column popcount: each column reduces to a 4-bit count.
  always_comb begin
    pc = '0;
    for (int unsigned c = 0; c < 15; c++) begin
      for (int unsigned r = 0; r < 15; r++) begin
        pc[c] = pc[c] + 4'(cols[c][r]);
      end
    end
  end

  // Shifted adder over the column counts; max 0x77FF1 fits in 19 bits.
  always_comb begin
    sum_d = '0;
    for (int unsigned c = 0; c < 15; c++) begin
      sum_d = sum_d + (19'(pc[c]) << c);
    end
  end

  // Output register; asynchronous clear discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dst0  = sum_q[0];
  assign dst1  = sum_q[1];
  assign dst2  = sum_q[2];
  assign dst3  = sum_q[3];
  assign dst4  = sum_q[4];
  assign dst5  = sum_q[5];
  assign dst6  = sum_q[6];
  assign dst7  = sum_q[7];
  assign dst8  = sum_q[8];
  assign dst9  = sum_q[9];
  assign dst10 = sum_q[10];
  assign dst11 = sum_q[11];
  assign dst12 = sum_q[12];
  assign dst13 = sum_q[13];
  assign dst14 = sum_q[14];
  assign dst15 = sum_q[15];
  assign dst16 = sum_q[16];
  assign dst17 = sum_q[17];
  assign dst18 = sum_q[18];

endmodule

// File: tb/tb_square15_compressor.sv
// Testbench for square15_compressor: directed table, back-to-back latency,
// asynchronous reset corners, and randomized cycles against a popcount model.
module tb_square15_compressor;

  logic        clk;
  logic        rst_n;
  logic [14:0] s [15];
  logic [18:0] dst;

  int n_vec;
  int n_err;

  typedef struct {
    string             name;
    logic [14:0][14:0] col;
    logic [18:0]       exp;
  } vec_t;

  vec_t tbl [8];

  square15_compressor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src0  (s[0]),  .src1  (s[1]),  .src2  (s[2]),  .src3  (s[3]),
    .src4  (s[4]),  .src5  (s[5]),  .src6  (s[6]),  .src7  (s[7]),
    .src8  (s[8]),  .src9  (s[9]),  .src10 (s[10]), .src11 (s[11]),
    .src12 (s[12]), .src13 (s[13]), .src14 (s[14]),
    .dst0  (dst[0]),  .dst1  (dst[1]),  .dst2  (dst[2]),  .dst3  (dst[3]),
    .dst4  (dst[4]),  .dst5  (dst[5]),  .dst6  (dst[6]),  .dst7  (dst[7]),
    .dst8  (dst[8]),  .dst9  (dst[9]),  .dst10 (dst[10]), .dst11 (dst[11]),
    .dst12 (dst[12]), .dst13 (dst[13]), .dst14 (dst[14]), .dst15 (dst[15]),
    .dst16 (dst[16]), .dst17 (dst[17]), .dst18 (dst[18])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: weighted popcount of the inputs currently driven.
  function automatic logic [18:0] ref_sum();
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < 15; i++) begin
      acc += $countones(s[i]) * (32'd1 << i);
    end
    return acc[18:0];
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  task automatic set_cols(input logic [14:0][14:0] c);
    for (int i = 0; i < 15; i++) s[i] = c[i];
  endtask

  task automatic fill(input logic [14:0] v);
    for (int i = 0; i < 15; i++) s[i] = v;
  endtask

  // Wait for the next rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [18:0] e;
    n_vec = 0;
    n_err = 0;

    // Directed table
    for (int k = 0; k < 8; k++) tbl[k].col = '0;
    tbl[0].name = "src0_lsb";      tbl[0].col[0]  = 15'h0001; tbl[0].exp = 19'h00001;
    tbl[1].name = "src14_single";  tbl[1].col[14] = 15'h4000; tbl[1].exp = 19'h04000;
    tbl[2].name = "src14_full";    tbl[2].col[14] = 15'h7FFF; tbl[2].exp = 19'h3C000;
    for (int i = 0; i < 15; i++) tbl[3].col[i] = 15'h0001;
    tbl[3].name = "ripple_ones";   tbl[3].exp = 19'h07FFF;
    for (int i = 0; i < 15; i++) tbl[4].col[i] = 15'h0003;
    tbl[4].name = "ripple_twos";   tbl[4].exp = 19'h0FFFE;
    for (int i = 0; i < 15; i++) tbl[5].col[i] = 15'h7FFF;
    tbl[5].name = "all_ones";      tbl[5].exp = 19'h77FF1;
    tbl[6].name = "all_zero";      tbl[6].exp = 19'h00000;
    tbl[7].name = "src7_5555";     tbl[7].col[7]  = 15'h5555; tbl[7].exp = 19'h00400;

    // Reset asserted with full inputs: outputs zero before any clock edge
    rst_n = 1'b0;
    fill(15'h7FFF);
    #1;
    check("reset_no_edge", dst, 19'h0);
    step();
    check("reset_held_edge", dst, 19'h0);

    // Release between edges, then one edge registers the full-scale sum
    #2 rst_n = 1'b1;
    step();
    check("release_first_edge", dst, 19'h77FF1);

    // Table, applied back-to-back: each result one cycle after its inputs
    for (int k = 0; k < 8; k++) begin
      set_cols(tbl[k].col);
      step();
      check(tbl[k].name, dst, tbl[k].exp);
    end

    // Hand sequence: ripple ones then twos on consecutive edges, with the
    // older value still visible until the second edge
    fill(15'h0001);
    step();
    check("b2b_first", dst, 19'h07FFF);
    fill(15'h0003);
    #2;
    check("b2b_hold", dst, 19'h07FFF);
    step();
    check("b2b_second", dst, 19'h0FFFE);

    // Mid-stream reset: pulse low between edges while inputs change
    fill(15'h7FFF);
    step();
    check("pre_reset_value", dst, 19'h77FF1);
    #1 rst_n = 1'b0;
    s[3] = 15'h00FF;
    s[9] = 15'h0000;
    #1;
    check("midreset_async_clear", dst, 19'h0);
    rst_n = 1'b1;
    s[0] = 15'h1234;
    e = ref_sum();
    #1;
    check("midreset_no_stale", dst, 19'h0);
    step();
    check("midreset_after_release", dst, e);

    // Random back-to-back cycles against the popcount model
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 15; i++) s[i] = 15'($urandom);
      if (n % 97 == 0) fill(15'h7FFF);
      e = ref_sum();
      step();
      check("random", dst, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
